// File: rtl/uba_intr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uba_intr_pkg
//  Purpose  : Shared types and defaults for the UBA interrupt responder.
//             - state_t : vector-cycle state encoding (2-bit)
//             - NDEV_DEF / VECW_DEF : default device count and vector width
//  Revision : 1.0  initial release
// ============================================================================
package uba_intr_pkg;

  localparam int NDEV_DEF = 4;
  localparam int VECW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uba_intr_resp_if.sv
`default_nettype none
// ============================================================================
//  Module   : uba_intr_resp_if
//  Purpose  : Device-interrupt / CPU-vector bundle for uba_intr_resp.
//  Signals  : devINTR  per-device request (level)
//             devVECT  per-device vectors, slice i = devVECT[i*VECW +: VECW]
//             devIACK  one-hot vector-cycle strobe to the granted device
//             cpuIREQ  interrupt pending to CPU
//             cpuIACK  CPU vector request (level)
//             cpuVALID cpuVECT/cpuNOVEC valid
//             cpuVECT  captured vector
//             cpuNOVEC acknowledge found no requester
//  Modports : slave  = responder (uba_intr_resp)
//             master = devices + CPU side
//  Revision : 1.0  initial release
// ============================================================================
interface uba_intr_resp_if
  import uba_intr_pkg::*;
#(
  parameter int NDEV = NDEV_DEF,
  parameter int VECW = VECW_DEF
);

  logic [NDEV-1:0]      devINTR;
  logic [NDEV*VECW-1:0] devVECT;
  logic [NDEV-1:0]      devIACK;
  logic                 cpuIREQ;
  logic                 cpuIACK;
  logic                 cpuVALID;
  logic [VECW-1:0]      cpuVECT;
  logic                 cpuNOVEC;

  modport slave (
    input  devINTR, devVECT, cpuIACK,
    output devIACK, cpuIREQ, cpuVALID, cpuVECT, cpuNOVEC
  );

  modport master (
    output devINTR, devVECT, cpuIACK,
    input  devIACK, cpuIREQ, cpuVALID, cpuVECT, cpuNOVEC
  );

endinterface
`default_nettype wire

// File: rtl/uba_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : uba_prio_enc
//  Purpose  : Combinational lowest-index-wins priority encoder.
//  Ports    : req  NDEV-bit request vector (bit 0 highest priority)
//             idx  index of lowest set bit (0 when none set)
//             any  at least one request set
//  Revision : 1.0  initial release
// ============================================================================
module uba_prio_enc #(
  parameter int NDEV = 4
) (
  input  logic [NDEV-1:0]         req,
  output logic [$clog2(NDEV)-1:0] idx,
  output logic                    any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Scan from the top down so the lowest set index is written last.
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (req[i]) idx = ($clog2(NDEV))'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uba_intr_resp.sv
`default_nettype none
// ============================================================================
//  Module   : uba_intr_resp
//  Purpose  : Bus-adapter interrupt responder. Forwards pending device
//             interrupts to the CPU and, on CPU acknowledge, runs the
//             two-cycle device IACK / vector capture handshake.
//  Ports    : clk  clock
//             rst  synchronous active-high reset
//             clr  IO bus initialize, same effect as rst
//             bus  uba_intr_resp_if.slave (device and CPU side signals)
//  Revision : 1.0  initial release
// ============================================================================
module uba_intr_resp
  import uba_intr_pkg::*;
#(
  parameter int NDEV = NDEV_DEF,
  parameter int VECW = VECW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  uba_intr_resp_if.slave   bus
);

  localparam int IDXW = $clog2(NDEV);

  state_t          state;
  state_t          stateNext;
  logic            reset;
  logic [IDXW-1:0] encIdx;
  logic            encAny;
  logic [IDXW-1:0] grant;
  logic            armed;
  logic            startAck;
  logic [VECW-1:0] grantVec;

  logic [NDEV-1:0] iackReg;
  logic            ireqReg;
  logic            validReg;
  logic [VECW-1:0] vectReg;
  logic            novecReg;

  assign reset = rst | clr;

  function automatic logic [NDEV-1:0] oneHot(input logic [IDXW-1:0] i);
    oneHot    = '0;
    oneHot[i] = 1'b1;
  endfunction

  uba_prio_enc #(.NDEV(NDEV)) uPrio (
    .req (bus.devINTR),
    .idx (encIdx),
    .any (encAny)
  );

  // A cycle starts only on a fresh rising cpuIACK: 'armed' is set by any
  // cycle with cpuIACK low and cleared when a cycle starts or on reset, so
  // a cpuIACK held across DONE or across a clr cannot re-acknowledge.
  assign startAck = (state == IDLE) && bus.cpuIACK && armed;

  assign grantVec = bus.devVECT[int'(grant)*VECW +: VECW];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (startAck) stateNext = encAny ? ACK1 : DONE;
      ACK1: stateNext = ACK2;
      ACK2: stateNext = DONE;
      DONE: if (!bus.cpuIACK) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Registered outputs; each value is loaded on the edge entering the state
  // in which it must be visible, so devIACK is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= '0;
      armed    <= 1'b0;
      iackReg  <= '0;
      ireqReg  <= 1'b0;
      validReg <= 1'b0;
      vectReg  <= '0;
      novecReg <= 1'b0;
    end else begin
      ireqReg <= encAny && (state == IDLE);

      if (startAck)          armed <= 1'b0;
      else if (!bus.cpuIACK) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (startAck) begin
            if (encAny) begin
              grant   <= encIdx;
              iackReg <= oneHot(encIdx);
            end else begin
              // Request withdrawn before the acknowledge was sampled.
              vectReg  <= '0;
              novecReg <= 1'b1;
              validReg <= 1'b1;
            end
          end
        end
        ACK1: iackReg <= oneHot(grant);
        ACK2: begin
          // Device has held its vector stable since ACK1; capture it now.
          iackReg  <= '0;
          vectReg  <= grantVec;
          novecReg <= 1'b0;
          validReg <= 1'b1;
        end
        DONE: if (!bus.cpuIACK) validReg <= 1'b0;
        default: iackReg <= '0;
      endcase
    end
  end

  assign bus.devIACK  = iackReg;
  assign bus.cpuIREQ  = ireqReg;
  assign bus.cpuVALID = validReg;
  assign bus.cpuVECT  = vectReg;
  assign bus.cpuNOVEC = novecReg;

endmodule
`default_nettype wire

// File: tb/tb_uba_intr_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uba_intr_resp
//  Purpose  : Self-checking bench for uba_intr_resp. Expected vector-cycle
//             results come from a lowest-index priority model, are queued
//             when the request pattern is set up and popped when the DUT
//             presents cpuVALID.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uba_intr_resp;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  uba_intr_resp_if #(.NDEV(4), .VECW(16)) bus ();

  uba_intr_resp #(.NDEV(4), .VECW(16)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] vect;
    logic        novec;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] vtab [4];
  int          checks   = 0;
  int          failures = 0;

  // Observations returned by doAck
  logic [3:0]  oMask;
  int          oPulse;
  int          oLat;
  logic [15:0] oVect;
  logic        oNovec;
  bit          oTimeout;
  bit          oExtra;
  bit          oIreq;
  exp_t        e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] intr);
    exp_t r;
    r.mask  = '0;
    r.vect  = '0;
    r.novec = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (intr[i]) begin
        r.mask     = '0;
        r.mask[i]  = 1'b1;
        r.vect     = vtab[i];
        r.novec    = 1'b0;
      end
    end
    return r;
  endfunction

  // Runs one CPU acknowledge and records what the DUT did; no judging here.
  task automatic doAck(input int holdExtra, input logic [3:0] lateMask);
    oMask = '0; oPulse = 0; oLat = 0; oVect = '0; oNovec = 1'b0;
    oTimeout = 1'b1; oExtra = 1'b0; oIreq = 1'b0;
    bus.cpuIACK = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.devIACK != 4'b0) begin
        oMask  = oMask | bus.devIACK;
        oPulse = oPulse + 1;
      end
      if (c == 1) bus.devINTR = bus.devINTR | lateMask;
      if (bus.cpuVALID) begin
        oLat = c; oVect = bus.cpuVECT; oNovec = bus.cpuNOVEC; oTimeout = 1'b0;
        break;
      end
    end
    for (int h = 0; h < holdExtra; h++) begin
      tick();
      if (bus.devIACK != 4'b0) oExtra = 1'b1;
      if (bus.cpuIREQ) oIreq = 1'b1;
    end
    bus.cpuIACK = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; bus.cpuIACK = 1'b0; bus.devINTR = 4'b0100;
    bus.devVECT = {vtab[3], vtab[2], vtab[1], vtab[0]};
    tick(); tick();
    checks++;
    if ({bus.devIACK, bus.cpuIREQ, bus.cpuVALID, bus.cpuVECT, bus.cpuNOVEC} !== 23'd0) begin
      failures++;
      $display("FAIL reset_in got iack=%b ireq=%b valid=%b vect=%o novec=%b exp all 0",
               bus.devIACK, bus.cpuIREQ, bus.cpuVALID, bus.cpuVECT, bus.cpuNOVEC);
    end
    bus.devINTR = 4'b0; rst = 1'b0;
    tick();
    checks++;
    if ({bus.devIACK, bus.cpuIREQ, bus.cpuVALID, bus.cpuVECT, bus.cpuNOVEC} !== 23'd0) begin
      failures++;
      $display("FAIL reset_out got iack=%b ireq=%b valid=%b exp all 0",
               bus.devIACK, bus.cpuIREQ, bus.cpuVALID);
    end
  endtask

  task automatic test_basic();
    bus.devINTR = 4'b0100;
    checks++;
    if (bus.cpuIREQ !== 1'b0) begin
      failures++; $display("FAIL basic_ireq_latency got %b exp 0", bus.cpuIREQ);
    end
    tick();
    checks++;
    if (bus.cpuIREQ !== 1'b1) begin
      failures++; $display("FAIL basic_ireq got %b exp 1", bus.cpuIREQ);
    end
    sb.push_back(model(bus.devINTR));
    doAck(0, 4'b0);
    e = sb.pop_front();
    checks++;
    if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec}) begin
      failures++;
      $display("FAIL basic_result got to=%0d mask=%b vect=%o novec=%b exp mask=%b vect=%o novec=%b",
               oTimeout, oMask, oVect, oNovec, e.mask, e.vect, e.novec);
    end
    checks++;
    if (oPulse !== 2 || oLat !== 3) begin
      failures++; $display("FAIL basic_timing got pulse=%0d lat=%0d exp pulse=2 lat=3", oPulse, oLat);
    end
    checks++;
    if (bus.cpuVALID !== 1'b0 || bus.cpuVECT !== 16'o340) begin
      failures++;
      $display("FAIL basic_after got valid=%b vect=%o exp valid=0 vect=340", bus.cpuVALID, bus.cpuVECT);
    end
  endtask

  task automatic test_priority();
    logic [3:0] pats [2];
    pats[0] = 4'b1010;
    pats[1] = 4'b1000;
    for (int p = 0; p < 2; p++) begin
      bus.devINTR = pats[p];
      tick();
      sb.push_back(model(bus.devINTR));
      doAck(0, 4'b0);
      e = sb.pop_front();
      checks++;
      if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec}) begin
        failures++;
        $display("FAIL priority_%0d got mask=%b vect=%o novec=%b exp mask=%b vect=%o novec=%b",
                 p, oMask, oVect, oNovec, e.mask, e.vect, e.novec);
      end
    end
  endtask

  task automatic test_late_arrival();
    bus.devINTR = 4'b0100;
    tick();
    sb.push_back(model(bus.devINTR));
    doAck(0, 4'b0001);
    e = sb.pop_front();
    checks++;
    if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec} || oPulse !== 2) begin
      failures++;
      $display("FAIL late_grant got mask=%b vect=%o pulse=%0d exp mask=%b vect=%o pulse=2",
               oMask, oVect, oPulse, e.mask, e.vect);
    end
    sb.push_back(model(bus.devINTR));
    doAck(0, 4'b0);
    e = sb.pop_front();
    checks++;
    if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec}) begin
      failures++;
      $display("FAIL late_next got mask=%b vect=%o exp mask=%b vect=%o", oMask, oVect, e.mask, e.vect);
    end
  endtask

  task automatic test_withdrawn();
    bus.devINTR = 4'b0;
    tick();
    sb.push_back(model(bus.devINTR));
    doAck(0, 4'b0);
    e = sb.pop_front();
    checks++;
    if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec} || oPulse !== 0 || oLat !== 1) begin
      failures++;
      $display("FAIL withdrawn got mask=%b vect=%o novec=%b pulse=%0d lat=%0d exp mask=%b vect=%o novec=%b pulse=0 lat=1",
               oMask, oVect, oNovec, oPulse, oLat, e.mask, e.vect, e.novec);
    end
    checks++;
    if (bus.cpuNOVEC !== 1'b1 || bus.cpuVALID !== 1'b0) begin
      failures++;
      $display("FAIL withdrawn_hold got novec=%b valid=%b exp novec=1 valid=0", bus.cpuNOVEC, bus.cpuVALID);
    end
  endtask

  task automatic test_clr_mid();
    bit seen;
    bus.devINTR = 4'b0010;
    tick();
    bus.cpuIACK = 1'b1;
    tick();
    checks++;
    if (bus.devIACK !== 4'b0010) begin
      failures++; $display("FAIL clr_ack1 got %b exp 0010", bus.devIACK);
    end
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if ({bus.devIACK, bus.cpuVALID, bus.cpuIREQ, bus.cpuNOVEC, bus.cpuVECT} !== 23'd0) begin
      failures++;
      $display("FAIL clr_effect got iack=%b valid=%b ireq=%b novec=%b vect=%o exp all 0",
               bus.devIACK, bus.cpuVALID, bus.cpuIREQ, bus.cpuNOVEC, bus.cpuVECT);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.devIACK != 4'b0 || bus.cpuVALID) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bus.cpuIREQ !== 1'b1) begin
      failures++;
      $display("FAIL clr_no_reack got activity=%b ireq=%b exp activity=0 ireq=1", seen, bus.cpuIREQ);
    end
    bus.cpuIACK = 1'b0;
    tick();
    sb.push_back(model(bus.devINTR));
    doAck(0, 4'b0);
    e = sb.pop_front();
    checks++;
    if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec}) begin
      failures++;
      $display("FAIL clr_retry got mask=%b vect=%o exp mask=%b vect=%o", oMask, oVect, e.mask, e.vect);
    end
  endtask

  task automatic test_iack_held();
    bus.devINTR = 4'b0001;
    tick();
    sb.push_back(model(bus.devINTR));
    doAck(10, 4'b0);
    e = sb.pop_front();
    checks++;
    if (oTimeout || {oMask, oVect, oNovec} !== {e.mask, e.vect, e.novec} || oPulse !== 2 || oExtra !== 1'b0) begin
      failures++;
      $display("FAIL held_single got mask=%b vect=%o pulse=%0d extra=%b exp mask=%b vect=%o pulse=2 extra=0",
               oMask, oVect, oPulse, oExtra, e.mask, e.vect);
    end
    checks++;
    if (oIreq !== 1'b0 || bus.cpuIREQ !== 1'b0) begin
      failures++;
      $display("FAIL held_ireq got hold=%b exit=%b exp 0 0", oIreq, bus.cpuIREQ);
    end
    tick();
    checks++;
    if (bus.cpuIREQ !== 1'b1) begin
      failures++; $display("FAIL held_ireq_return got %b exp 1", bus.cpuIREQ);
    end
  endtask

  initial begin
    vtab[0] = 16'o300;
    vtab[1] = 16'o310;
    vtab[2] = 16'o340;
    vtab[3] = 16'o330;
    test_reset();
    test_basic();
    test_priority();
    test_late_arrival();
    test_withdrawn();
    test_clr_mid();
    test_iack_held();
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL scoreboard_left got %0d exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
